decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 8, element width.
- VECTOR_SIZE, 6, lanes per vector register.
- REGNUM, 16, registers per file (scalar and vector).
- ADDRESS_WIDTH, 4, register address width.
- OPCODE_WIDTH, 4, opcode width.
- INSTRUCTION_WIDTH, 32, instruction width.
- IMM_WIDTH, 16, raw immediate width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-low.
- inValid, in, 1, instruction offered.
- inReady, out, 1, instruction accepted this cycle.
- instruction, in, INSTRUCTION_WIDTH, instruction word.
- wbEnableScalar, in, 1, scalar writeback strobe.
- wbEnableVector, in, 1, vector writeback strobe.
- wbAddress, in, ADDRESS_WIDTH, writeback register.
- wbScalarData, in, DATA_WIDTH, scalar writeback data.
- wbVectorData, in, VECTOR_SIZE x DATA_WIDTH, vector writeback data.
- outValid, out, 1, decoded bundle valid.
- outReady, in, 1, downstream accepts bundle.
- opcode, out, OPCODE_WIDTH, decoded opcode.
- isVector, out, 1, vector-class instruction.
- writesDest, out, 1, instruction writes a destination register.
- regDestinationAddress, reg1Address, reg2Address, out, ADDRESS_WIDTH each, decoded addresses.
- reg1ScalarContent, reg2ScalarContent, inmediate, out, DATA_WIDTH each, operands and immediate.
- reg1VectorContent, reg2VectorContent, out, VECTOR_SIZE x DATA_WIDTH each, vector operands.

Function
REQ-003 Fields SHALL be: opcode [23:20], rd [19:16], rs1 [15:12], rs2 [11:8], imm [15:0], isVector [24], writesDest [25].
REQ-004 inmediate SHALL be imm sign-extended to DATA_WIDTH when DATA_WIDTH >= IMM_WIDTH, else imm[DATA_WIDTH-1:0].
REQ-005 Module SHALL hold one scalar and one vector register file (REGNUM entries each), written on the rising clock edge when the matching wbEnable is high.
REQ-006 Per-file scoreboard SHALL hold one pending bit per register.
REQ-007 Hazard SHALL be asserted when, in the file selected by isVector, rs1, rs2 or (if writesDest) rd is pending.
REQ-008 inReady SHALL equal inValid-independent (!hazard && (!outValid || outReady)); a transfer occurs on inValid && inReady.
REQ-009 On transfer, all outputs SHALL register decoded fields and operands read that cycle; latency 1 cycle; outValid SHALL then be 1.
REQ-010 outValid && !outReady SHALL hold all outputs stable; outValid SHALL clear on outReady with no new transfer.
REQ-011 Transfer with writesDest SHALL set pending[rd] in the selected file; writeback SHALL clear pending[wbAddress] in its file; a simultaneous set and clear of the same bit SHALL resolve to set.
REQ-012 wbEnableScalar and wbEnableVector both high SHALL write both files.

Reset
REQ-013 With reset low at a rising edge, outValid, all data outputs, all scoreboard bits and all register contents SHALL become 0; inReady SHALL be 0 during reset.
REQ-014 Reset mid-operation SHALL discard the held bundle and ignore concurrent writebacks.

Configuration
REQ-015 With DECODE_BYPASS_EN defined, a same-cycle writeback to a read register SHALL be forwarded to the operand, and its pending bit SHALL count as clear in that cycle's hazard check.
REQ-016 Without DECODE_BYPASS_EN, operands SHALL come from the file only; the hazard SHALL stay asserted in the writeback cycle and the transfer SHALL occur no earlier than the next cycle.

Structure
REQ-017 Package decode_pkg SHALL hold field-position constants, the isVector/writesDest bit indices, and the vector-data typedef.
REQ-018 Scoreboard SHALL be sub-module decode_scoreboard, instantiated once per file.

Verification
REQ-019 Reset, then write scalar r3=0x5A, then issue scalar instruction with rs1=3 -> reg1ScalarContent=0x5A, outValid 1 cycle after transfer.
REQ-020 Issue instruction writing r4, then instruction reading r4 -> inReady=0 until wbEnableScalar, wbAddress=4; resumes in the same cycle with DECODE_BYPASS_EN, one cycle later without.
REQ-021 Hold outReady=0 for 3 cycles with a valid bundle -> outputs stable, inReady=0; next instruction accepted in the cycle outReady=1.
REQ-022 imm=0xFF80, DATA_WIDTH=8 -> inmediate=0x80; DATA_WIDTH=32 -> 0xFFFFFF80.
REQ-023 Vector instruction writing v2 while a scalar instruction reads r2 -> no stall (separate scoreboards).
REQ-024 Pull reset low while outValid=1 and r5 pending -> outValid=0 and r5 clear next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: instruction field positions,
// the class/destination flag bits and the default vector-data type.
package decode_pkg;

  // Instruction field positions (least significant bit of each field)
  localparam int OPCODE_LSB = 20;
  localparam int RD_LSB     = 16;
  localparam int RS1_LSB    = 12;
  localparam int RS2_LSB    = 8;
  localparam int IMM_LSB    = 0;

  // Single-bit instruction flags
  localparam int IS_VECTOR_BIT   = 24;
  localparam int WRITES_DEST_BIT = 25;

  // Default vector-register shape: lanes x element width
  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_VECTOR_SIZE = 6;

  typedef logic [DEFAULT_VECTOR_SIZE-1:0][DEFAULT_DATA_WIDTH-1:0] vec_data_t;

endpackage

// File: rtl/decode_scoreboard.sv
// One pending bit per register. A writeback clears its bit; an issued
// instruction that writes a destination sets its bit. If both hit the same
// bit in one cycle the set wins, because the new writer is still in flight.
module decode_scoreboard #(
  parameter int REGNUM        = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [ADDRESS_WIDTH-1:0] set_addr,
  input  logic                     clr_en,
  input  logic [ADDRESS_WIDTH-1:0] clr_addr,
  output logic [REGNUM-1:0]        pending
);

  logic [REGNUM-1:0] pending_d;
  logic [REGNUM-1:0] pending_q;

  // Next pending state: clear from writeback first, then set from issue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    pending_d = pending_q;
    // NOTE: blocking assignments here on purpose; the later set must override the earlier clear within this block.
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
  end

  // Pending-bit storage with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/decode_pipe.sv
// Decode stage with scalar and vector register files, per-file scoreboards
// and a one-entry registered output bundle with valid/ready handshake.
// Optional feature: define DECODE_BYPASS_EN to forward same-cycle writebacks
// into operand reads and to treat the written register as no longer pending.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int VECTOR_SIZE       = 6,
  parameter int REGNUM            = 16,
  parameter int ADDRESS_WIDTH     = 4,
  parameter int OPCODE_WIDTH      = 4,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int IMM_WIDTH         = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               inValid,
  output logic                               inReady,
  input  logic [INSTRUCTION_WIDTH-1:0]       instruction,
  input  logic                               wbEnableScalar,
  input  logic                               wbEnableVector,
  input  logic [ADDRESS_WIDTH-1:0]           wbAddress,
  input  logic [DATA_WIDTH-1:0]              wbScalarData,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]  wbVectorData,
  output logic                               outValid,
  input  logic                               outReady,
  output logic [OPCODE_WIDTH-1:0]            opcode,
  output logic                               isVector,
  output logic                               writesDest,
  output logic [ADDRESS_WIDTH-1:0]           regDestinationAddress,
  output logic [ADDRESS_WIDTH-1:0]           reg1Address,
  output logic [ADDRESS_WIDTH-1:0]           reg2Address,
  output logic [DATA_WIDTH-1:0]              reg1ScalarContent,
  output logic [DATA_WIDTH-1:0]              reg2ScalarContent,
  output logic [DATA_WIDTH-1:0]              inmediate,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0]  reg1VectorContent,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0]  reg2VectorContent
);

  localparam int VW = VECTOR_SIZE * DATA_WIDTH;

  // Decoded fields of the offered instruction
  logic [OPCODE_WIDTH-1:0]  dec_opcode;
  logic [ADDRESS_WIDTH-1:0] dec_rd, dec_rs1, dec_rs2;
  logic                     dec_is_vector, dec_writes_dest;
  logic [DATA_WIDTH-1:0]    dec_imm;
  logic                     unused_instr_bits;

  assign dec_opcode      = instruction[OPCODE_LSB +: OPCODE_WIDTH];
  assign dec_rd          = instruction[RD_LSB +: ADDRESS_WIDTH];
  assign dec_rs1         = instruction[RS1_LSB +: ADDRESS_WIDTH];
  assign dec_rs2         = instruction[RS2_LSB +: ADDRESS_WIDTH];
  assign dec_is_vector   = instruction[IS_VECTOR_BIT];
  assign dec_writes_dest = instruction[WRITES_DEST_BIT];
  // A signed size cast sign-extends when widening and keeps the low bits when narrowing.
  assign dec_imm         = DATA_WIDTH'($signed(instruction[IMM_LSB +: IMM_WIDTH]));
  assign unused_instr_bits = ^instruction[INSTRUCTION_WIDTH-1:WRITES_DEST_BIT+1];

  // Register files and scoreboards
  logic [DATA_WIDTH-1:0] srf_q [REGNUM];
  logic [DATA_WIDTH-1:0] srf_d [REGNUM];
  logic [VW-1:0]         vrf_q [REGNUM];
  logic [VW-1:0]         vrf_d [REGNUM];
  logic [REGNUM-1:0]     scalar_pending, vector_pending;
  logic [REGNUM-1:0]     scalar_clear, vector_clear, sel_pending;
  logic                  hazard, transfer;

  // Operand values as seen by this cycle's instruction
  logic [DATA_WIDTH-1:0] rs1_scalar, rs2_scalar;
  logic [VW-1:0]         rs1_vector, rs2_vector;

  // Output bundle flops
  logic                     out_valid_q, out_valid_d;
  logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
  logic                     is_vector_q, is_vector_d;
  logic                     writes_dest_q, writes_dest_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d, rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
  logic [DATA_WIDTH-1:0]    rs1_scalar_q, rs1_scalar_d, rs2_scalar_q, rs2_scalar_d, imm_q, imm_d;
  logic [VW-1:0]            rs1_vector_q, rs1_vector_d, rs2_vector_q, rs2_vector_d;

  decode_scoreboard #(.REGNUM(REGNUM), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_scalar_sb (
    .clock    (clock),
    .reset    (reset),
    .set_en   (transfer && dec_writes_dest && !dec_is_vector),
    .set_addr (dec_rd),
    .clr_en   (wbEnableScalar),
    .clr_addr (wbAddress),
    .pending  (scalar_pending)
  );

  decode_scoreboard #(.REGNUM(REGNUM), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_vector_sb (
    .clock    (clock),
    .reset    (reset),
    .set_en   (transfer && dec_writes_dest && dec_is_vector),
    .set_addr (dec_rd),
    .clr_en   (wbEnableVector),
    .clr_addr (wbAddress),
    .pending  (vector_pending)
  );

  // Operand read (optionally forwarded) and hazard detection in the selected file.
  always_comb begin
    rs1_scalar   = srf_q[dec_rs1];
    rs2_scalar   = srf_q[dec_rs2];
    rs1_vector   = vrf_q[dec_rs1];
    rs2_vector   = vrf_q[dec_rs2];
    scalar_clear = '0;
    vector_clear = '0;
`ifdef DECODE_BYPASS_EN
    if (wbEnableScalar) begin
      scalar_clear[wbAddress] = 1'b1;
      if (wbAddress == dec_rs1) rs1_scalar = wbScalarData;
      if (wbAddress == dec_rs2) rs2_scalar = wbScalarData;
    end
    if (wbEnableVector) begin
      vector_clear[wbAddress] = 1'b1;
      if (wbAddress == dec_rs1) rs1_vector = wbVectorData;
      if (wbAddress == dec_rs2) rs2_vector = wbVectorData;
    end
`endif
    sel_pending = dec_is_vector ? (vector_pending & ~vector_clear)
                                : (scalar_pending & ~scalar_clear);
    hazard = sel_pending[dec_rs1] || sel_pending[dec_rs2] ||
             (dec_writes_dest && sel_pending[dec_rd]);
  end

  assign inReady  = reset && !hazard && (!out_valid_q || outReady);
  assign transfer = inValid && inReady;

  // Output bundle: load on transfer, drop valid when consumed, otherwise hold.
  always_comb begin
    out_valid_d   = out_valid_q;
    opcode_d      = opcode_q;
    is_vector_d   = is_vector_q;
    writes_dest_d = writes_dest_q;
    rd_addr_d     = rd_addr_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rs1_scalar_d  = rs1_scalar_q;
    rs2_scalar_d  = rs2_scalar_q;
    imm_d         = imm_q;
    rs1_vector_d  = rs1_vector_q;
    rs2_vector_d  = rs2_vector_q;
    if (transfer) begin
      out_valid_d   = 1'b1;
      opcode_d      = dec_opcode;
      is_vector_d   = dec_is_vector;
      writes_dest_d = dec_writes_dest;
      rd_addr_d     = dec_rd;
      rs1_addr_d    = dec_rs1;
      rs2_addr_d    = dec_rs2;
      rs1_scalar_d  = rs1_scalar;
      rs2_scalar_d  = rs2_scalar;
      imm_d         = dec_imm;
      rs1_vector_d  = rs1_vector;
      rs2_vector_d  = rs2_vector;
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end
  end

  // Register-file writeback; both files may be written in the same cycle.
  always_comb begin
    srf_d = srf_q;
    vrf_d = vrf_q;
    if (wbEnableScalar) srf_d[wbAddress] = wbScalarData;
    if (wbEnableVector) vrf_d[wbAddress] = wbVectorData;
  end

  // All state, with synchronous reset that also drops concurrent writebacks.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      opcode_q      <= '0;
      is_vector_q   <= 1'b0;
      writes_dest_q <= 1'b0;
      rd_addr_q     <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rs1_scalar_q  <= '0;
      rs2_scalar_q  <= '0;
      imm_q         <= '0;
      rs1_vector_q  <= '0;
      rs2_vector_q  <= '0;
      // NOTE: the register files are reset because their contents must read as zero afterwards; this rules out RAM macros.
      for (int i = 0; i < REGNUM; i++) begin
        srf_q[i] <= '0;
        vrf_q[i] <= '0;
      end
    end else begin
      out_valid_q   <= out_valid_d;
      opcode_q      <= opcode_d;
      is_vector_q   <= is_vector_d;
      writes_dest_q <= writes_dest_d;
      rd_addr_q     <= rd_addr_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rs1_scalar_q  <= rs1_scalar_d;
      rs2_scalar_q  <= rs2_scalar_d;
      imm_q         <= imm_d;
      rs1_vector_q  <= rs1_vector_d;
      rs2_vector_q  <= rs2_vector_d;
      srf_q         <= srf_d;
      vrf_q         <= vrf_d;
    end
  end

  assign outValid              = out_valid_q;
  assign opcode                = opcode_q;
  assign isVector              = is_vector_q;
  assign writesDest            = writes_dest_q;
  assign regDestinationAddress = rd_addr_q;
  assign reg1Address           = rs1_addr_q;
  assign reg2Address           = rs2_addr_q;
  assign reg1ScalarContent     = rs1_scalar_q;
  assign reg2ScalarContent     = rs2_scalar_q;
  assign inmediate             = imm_q;
  assign reg1VectorContent     = rs1_vector_q;
  assign reg2VectorContent     = rs2_vector_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed scenarios followed by random
// traffic, all compared against a behavioural model of the decode stage.
module tb_decode_pipe;
  import decode_pkg::*;

`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid, inReady, outValid, outReady;
  logic [31:0] instruction;
  logic        wbEnableScalar, wbEnableVector;
  logic [3:0]  wbAddress;
  logic [7:0]  wbScalarData;
  logic [47:0] wbVectorData;
  logic [3:0]  opcode, regDestinationAddress, reg1Address, reg2Address;
  logic        isVector, writesDest;
  logic [7:0]  reg1ScalarContent, reg2ScalarContent, inmediate;
  logic [47:0] reg1VectorContent, reg2VectorContent;

  // Second instance with 32-bit elements, used only for immediate extension
  logic         inValid32;
  logic [31:0]  inmediate32;
  logic         unused32_in_ready, unused32_out_valid, unused32_vec, unused32_wd;
  logic [3:0]   unused32_op, unused32_rd, unused32_r1a, unused32_r2a;
  logic [31:0]  unused32_r1s, unused32_r2s;
  logic [191:0] unused32_r1v, unused32_r2v;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  decode_pipe dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .instruction(instruction), .wbEnableScalar(wbEnableScalar),
    .wbEnableVector(wbEnableVector), .wbAddress(wbAddress),
    .wbScalarData(wbScalarData), .wbVectorData(wbVectorData),
    .outValid(outValid), .outReady(outReady), .opcode(opcode),
    .isVector(isVector), .writesDest(writesDest),
    .regDestinationAddress(regDestinationAddress), .reg1Address(reg1Address),
    .reg2Address(reg2Address), .reg1ScalarContent(reg1ScalarContent),
    .reg2ScalarContent(reg2ScalarContent), .inmediate(inmediate),
    .reg1VectorContent(reg1VectorContent), .reg2VectorContent(reg2VectorContent)
  );

  decode_pipe #(.DATA_WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .inValid(inValid32), .inReady(unused32_in_ready),
    .instruction(instruction), .wbEnableScalar(1'b0), .wbEnableVector(1'b0),
    .wbAddress(4'd0), .wbScalarData(32'd0), .wbVectorData(192'd0),
    .outValid(unused32_out_valid), .outReady(1'b1), .opcode(unused32_op),
    .isVector(unused32_vec), .writesDest(unused32_wd),
    .regDestinationAddress(unused32_rd), .reg1Address(unused32_r1a),
    .reg2Address(unused32_r2a), .reg1ScalarContent(unused32_r1s),
    .reg2ScalarContent(unused32_r2s), .inmediate(inmediate32),
    .reg1VectorContent(unused32_r1v), .reg2VectorContent(unused32_r2v)
  );

  // Reference model state
  logic [7:0]  m_srf [16];
  logic [47:0] m_vrf [16];
  bit          m_sp [16];
  bit          m_vp [16];
  bit          m_valid;
  logic [3:0]  m_op, m_rd, m_r1a, m_r2a;
  bit          m_vec, m_wd;
  logic [7:0]  m_r1s, m_r2s, m_imm;
  logic [47:0] m_r1v, m_r2v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit wd, input bit vec, input logic [3:0] op,
                                     input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [3:0] rs2, input logic [7:0] lo);
    return {6'b0, wd, vec, op, rd, rs1, rs2, lo};
  endfunction

  // A register blocks issue if pending, unless forwarding sees its writeback now.
  function automatic bit busy(input bit vec, input logic [3:0] a);
    if (vec) return m_vp[a] && !(BYP && wbEnableVector && wbAddress == a);
    return m_sp[a] && !(BYP && wbEnableScalar && wbAddress == a);
  endfunction

  function automatic logic [7:0] read_s(input logic [3:0] a);
    return (BYP && wbEnableScalar && wbAddress == a) ? wbScalarData : m_srf[a];
  endfunction

  function automatic logic [47:0] read_v(input logic [3:0] a);
    return (BYP && wbEnableVector && wbAddress == a) ? wbVectorData : m_vrf[a];
  endfunction

  // One clock: check inReady against the model, advance the model, check outputs.
  task automatic cycle();
    logic [3:0] op, rd, r1, r2;
    bit vec, wd, exp_ready, check_data;
    #1;
    op  = instruction[23:20];
    rd  = instruction[19:16];
    r1  = instruction[15:12];
    r2  = instruction[11:8];
    vec = instruction[24];
    wd  = instruction[25];
    exp_ready = reset && !(busy(vec, r1) || busy(vec, r2) || (wd && busy(vec, rd)))
                && (!m_valid || outReady);
    chk("inReady", inReady, exp_ready);
    check_data = 1'b0;
    if (!reset) begin
      m_valid = 0; m_op = 0; m_rd = 0; m_r1a = 0; m_r2a = 0; m_vec = 0; m_wd = 0;
      m_r1s = 0; m_r2s = 0; m_imm = 0; m_r1v = 0; m_r2v = 0;
      for (int i = 0; i < 16; i++) begin
        m_srf[i] = 0; m_vrf[i] = 0; m_sp[i] = 0; m_vp[i] = 0;
      end
      check_data = 1'b1;
    end else begin
      if (inValid && exp_ready) begin
        m_valid = 1; m_op = op; m_rd = rd; m_r1a = r1; m_r2a = r2; m_vec = vec; m_wd = wd;
        m_r1s = read_s(r1); m_r2s = read_s(r2);
        m_r1v = read_v(r1); m_r2v = read_v(r2);
        m_imm = instruction[7:0];
      end else if (outReady) begin
        m_valid = 0;
      end
      if (wbEnableScalar) begin m_srf[wbAddress] = wbScalarData; m_sp[wbAddress] = 0; end
      if (wbEnableVector) begin m_vrf[wbAddress] = wbVectorData; m_vp[wbAddress] = 0; end
      if (inValid && exp_ready && wd) begin
        if (vec) m_vp[rd] = 1; else m_sp[rd] = 1;
      end
      check_data = m_valid;
    end
    @(posedge clock);
    #1;
    chk("outValid", outValid, m_valid);
    if (check_data) begin
      chk("opcode", opcode, m_op);
      chk("isVector", isVector, m_vec);
      chk("writesDest", writesDest, m_wd);
      chk("rdAddr", regDestinationAddress, m_rd);
      chk("rs1Addr", reg1Address, m_r1a);
      chk("rs2Addr", reg2Address, m_r2a);
      chk("rs1Scalar", reg1ScalarContent, m_r1s);
      chk("rs2Scalar", reg2ScalarContent, m_r2s);
      chk("imm", inmediate, m_imm);
      chk("rs1Vector", reg1VectorContent, m_r1v);
      chk("rs2Vector", reg2VectorContent, m_r2v);
    end
  endtask

  initial begin
    reset = 1'b0; inValid = 1'b0; outReady = 1'b1; instruction = '0;
    wbEnableScalar = 1'b0; wbEnableVector = 1'b0; wbAddress = '0;
    wbScalarData = '0; wbVectorData = '0; inValid32 = 1'b0;
    m_valid = 0;
    for (int i = 0; i < 16; i++) begin m_sp[i] = 0; m_vp[i] = 0; end

    // Reset: everything zero, no acceptance
    cycle(); cycle();
    reset = 1'b1;

    // Scalar writeback then read through rs1
    wbEnableScalar = 1'b1; wbAddress = 4'd3; wbScalarData = 8'h5A;
    cycle();
    wbEnableScalar = 1'b0;
    inValid = 1'b1; instruction = mk(0, 0, 4'h1, 4'h0, 4'h3, 4'h0, 8'h00);
    cycle();
    inValid = 1'b0;
    chk("req019_valid", outValid, 1'b1);
    chk("req019_rs1", reg1ScalarContent, 8'h5A);
    cycle();

    // Read-after-write stall on r4 released by writeback
    inValid = 1'b1; instruction = mk(1, 0, 4'h2, 4'h4, 4'h1, 4'h1, 8'h00);
    cycle();
    instruction = mk(0, 0, 4'h3, 4'h0, 4'h4, 4'h1, 8'h00);
    cycle(); cycle();
    wbEnableScalar = 1'b1; wbAddress = 4'd4; wbScalarData = 8'h77;
    cycle();
    wbEnableScalar = 1'b0;
    cycle();
    inValid = 1'b0;
    chk("req020_rs1", reg1ScalarContent, 8'h77);
    cycle();

    // Backpressure: bundle held for three cycles, next accepted on release
    inValid = 1'b1; instruction = mk(0, 0, 4'h5, 4'h0, 4'h1, 4'h2, 8'h11);
    cycle();
    outReady = 1'b0; instruction = mk(0, 0, 4'h6, 4'h0, 4'h2, 4'h3, 8'h22);
    cycle(); cycle(); cycle();
    chk("req021_held_op", opcode, 4'h5);
    outReady = 1'b1;
    cycle();
    chk("req021_next_op", opcode, 4'h6);
    inValid = 1'b0;
    cycle();

    // Immediate extension / truncation
    inValid = 1'b1; inValid32 = 1'b1; instruction = mk(0, 0, 4'h7, 4'h0, 4'hF, 4'hF, 8'h80);
    cycle();
    inValid = 1'b0; inValid32 = 1'b0;
    chk("req022_imm8", inmediate, 8'h80);
    chk("req022_imm32", inmediate32, 32'hFFFF_FF80);

    // Separate scoreboards: pending v2 does not block a scalar read of r2
    inValid = 1'b1; instruction = mk(1, 1, 4'h8, 4'h2, 4'h0, 4'h0, 8'h00);
    cycle();
    instruction = mk(0, 0, 4'h9, 4'h0, 4'h2, 4'h2, 8'h00);
    cycle();
    chk("req023_op", opcode, 4'h9);
    inValid = 1'b0;
    wbEnableVector = 1'b1; wbAddress = 4'd2; wbVectorData = 48'h0102_0304_0506;
    cycle();
    wbEnableVector = 1'b0;
    cycle();

    // Reset mid-operation with a held bundle, pending r5 and a concurrent writeback
    inValid = 1'b1; outReady = 1'b0; instruction = mk(1, 0, 4'hA, 4'h5, 4'h0, 4'h0, 8'h00);
    cycle();
    inValid = 1'b0;
    cycle();
    reset = 1'b0; wbEnableScalar = 1'b1; wbAddress = 4'd6; wbScalarData = 8'hEE;
    cycle();
    reset = 1'b1; wbEnableScalar = 1'b0; outReady = 1'b1;
    chk("req024_valid", outValid, 1'b0);
    inValid = 1'b1; instruction = mk(0, 0, 4'hB, 4'h0, 4'h5, 4'h6, 8'h00);
    cycle();
    chk("req024_op", opcode, 4'hB);
    chk("req024_rs2", reg2ScalarContent, 8'h00);
    inValid = 1'b0;
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      inValid        = ($urandom_range(0, 3) != 0);
      outReady       = ($urandom_range(0, 3) != 0);
      instruction    = $urandom();
      wbEnableScalar = ($urandom_range(0, 2) == 0);
      wbEnableVector = ($urandom_range(0, 2) == 0);
      wbAddress      = 4'($urandom_range(0, 15));
      wbScalarData   = 8'($urandom());
      wbVectorData   = 48'({$urandom(), $urandom()});
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
